tc_tile_sched: RTL and testbench
================================

# tc_tile_sched

Tile scheduler that sequences operand beats into `tc_array` and accumulates its per-beat outputs into a finished result tile. Accepts one command giving the K-step count. Pulls matched A/B operand vectors from upstream buffers via valid/ready, drives the array inputs, and tracks the array's fixed pipeline latency. Returns the TILE_M-lane accumulated sums over a valid/ready result port. Sits between the operand buffers and `tc_array`, one instance per array.

## Interface
- `N_UNIT`, 32, multiplier units in the array (operand vector = N_UNIT lanes)
- `TILE_M`, 4, output lanes of the array
- `TILE_K`, 8, reduction width per lane (N_UNIT = TILE_M*TILE_K)
- `DW_DATA`, 8, operand and array-output lane width
- `DW_ACC`, 24, accumulator lane width (≥ DW_DATA)
- `DW_CNT`, 8, K-step counter width
- `ARRAY_LAT`, 2, cycles from registered `arr_in_*` to matching `arr_out` (≥1)
- `clk` in 1, single clock, rising edge
- `reset` in 1, asynchronous, active-low; all state cleared while low
- `cmd_valid` in 1 / `cmd_ready` out 1 / `cmd_k_steps` in DW_CNT, job command
- `a_valid` in 1 / `a_ready` out 1 / `a_data` in N_UNIT*DW_DATA, A operand beat
- `b_valid` in 1 / `b_ready` out 1 / `b_data` in N_UNIT*DW_DATA, B operand beat
- `arr_in_a` out N_UNIT*DW_DATA, `arr_in_b` out N_UNIT*DW_DATA, registered array inputs
- `arr_out` in TILE_M*DW_DATA, array output (unsigned lanes, lane 0 = LSBs)
- `res_valid` out 1 / `res_ready` in 1 / `res_data` out TILE_M*DW_ACC, result tile
- `busy` out 1, high in any state but IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN, OUT.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch `k_steps`, clear accumulators and counters. Go to RUN if `k_steps`>0, else go straight to OUT with a zero result.
- RUN: a beat issues when `a_valid && b_valid`. Use a joint handshake: `a_ready` = `b_ready` = RUN && `a_valid` && `b_valid`, so both ports accept on the same edge.
  - On issue: `arr_in_a`/`arr_in_b` ← data, `issue_cnt`++.
  - On a non-issue cycle: `arr_in_*` ← 0 (bubble).
  - When `issue_cnt` reaches `k_steps`, go to DRAIN. If `ARRAY_LAT` completes on the same edge, go to OUT directly.
- Tag shift register, `ARRAY_LAT` deep, marks issued beats. When a tag exits:
  - each lane acc += zero-extended `arr_out` lane;
  - `acc_cnt`++.
- DRAIN: no issue, ready low. When `acc_cnt` == `k_steps`, go to OUT.
- OUT: `res_valid`=1 and `res_data`=acc, both held stable until `res_ready`. On the handshake edge, go to IDLE.
- Arithmetic: accumulation is modulo 2^DW_ACC, unless `TC_SCHED_SAT_EN` is defined.
- Operand stalls (either valid low) only insert bubbles. Correctness is unaffected.

## Timing
- Reset values: `cmd_ready`=0 while `reset` is low, then 1 in IDLE after release. `a_ready`=`b_ready`=0, `arr_in_a`=`arr_in_b`=0, `res_valid`=0, `res_data`=0, `busy`=0. State = IDLE, all counters and tags = 0.
- Latency with no stalls, cmd accepted at edge 0:
  - beats issue at edges 1..K;
  - beat at edge e is accumulated at edge e+ARRAY_LAT;
  - `res_valid` rises after edge K+ARRAY_LAT.
- Back-to-back jobs: the next `cmd_ready` comes one cycle after the result handshake. No overlap between jobs.
- `cmd_k_steps` = 2^DW_CNT−1 is legal. Counters do not wrap within a job.
- A held `res_ready`=0 stalls indefinitely. No inputs are accepted meanwhile.
- Reset asserted mid-job: in-flight beats and the partial sum are discarded. The block returns to IDLE with no result emitted.
- `cmd_valid` outside IDLE is ignored (`cmd_ready`=0).

## Configuration
- `TC_SCHED_SAT_EN` defined: each accumulator lane saturates at 2^DW_ACC−1 and stays there for the rest of the job.
- `TC_SCHED_SAT_EN` undefined: lanes wrap modulo 2^DW_ACC.
- Port list is the same in both builds.

## Structure
- Shared package `tc_pkg` holds:
  - the FSM state enum (IDLE/RUN/DRAIN/OUT);
  - default constants N_UNIT/TILE_M/TILE_K/DW_DATA;
  - the default DW_ACC.
- One sub-module, `tc_acc_lane`: a single-lane clear/add accumulator, with saturation under the macro. It is instantiated TILE_M times.

## Test plan
- Basic job: stub array returns lanes {40,30,20,10} (lane3..0) each beat, ARRAY_LAT=2, K=3, operands always valid → lanes {120,90,60,30}; `res_valid` rises after edge 5 relative to cmd accept.
- Stalls: K=4, `b_valid` toggles 1,0,0,1,1,0,1 → exactly 4 joint handshakes, `a_ready` never high while `b_valid`=0, same sums as an unstalled run. `arr_in_*`=0 on bubble cycles.
- K=0: cmd accepted → `res_valid` on the next cycle with `res_data`=0, no operand handshakes.
- Overflow, DW_ACC=10, 5 beats of lane value 255 → without macro each lane = 251; with `TC_SCHED_SAT_EN` each lane = 1023.
- Backpressure and restart: `res_ready` low for 6 cycles → `res_data` stable and `cmd_ready`=0 throughout. After the handshake, a second K=2 job yields fresh sums (no carry-over).
- Reset mid-job: assert `reset` low during RUN after 2 of K=5 beats → all outputs go to reset values immediately. After release, a new K=1 job returns only its own sum.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared types and default geometry for the tile scheduler and its accumulator lanes.
package tc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int N_UNIT_DEF  = 32;
  localparam int TILE_M_DEF  = 4;
  localparam int TILE_K_DEF  = 8;
  localparam int DW_DATA_DEF = 8;
  localparam int DW_ACC_DEF  = 24;

endpackage

// File: rtl/tc_acc_lane.sv
// Single accumulator lane: synchronous clear, conditional add of an unsigned lane value.
// TC_SCHED_SAT_EN selects saturation at all-ones instead of modulo wrap.
module tc_acc_lane
  import tc_pkg::*;
#(
  parameter int DW_DATA = DW_DATA_DEF,
  parameter int DW_ACC  = DW_ACC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               add_en,
  input  logic [DW_DATA-1:0] add_val,
  output logic [DW_ACC-1:0]  acc
);

`ifdef TC_SCHED_SAT_EN
  // One extra bit catches the carry; once pinned at all-ones the lane stays there.
  logic [DW_ACC:0] sum;
  assign sum = {1'b0, acc} + {{(DW_ACC + 1 - DW_DATA){1'b0}}, add_val};
`else
  logic [DW_ACC-1:0] sum;
  assign sum = acc + {{(DW_ACC - DW_DATA){1'b0}}, add_val};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add_en) begin
`ifdef TC_SCHED_SAT_EN
      acc <= sum[DW_ACC] ? '1 : sum[DW_ACC-1:0];
`else
      acc <= sum;
`endif
    end
  end

endmodule

// File: rtl/tc_tile_sched.sv
// Tile scheduler: issues joint A/B beats into tc_array, tracks its fixed latency with a tag
// pipe and accumulates per-lane results. Optional TC_SCHED_SAT_EN makes the lanes saturate.
module tc_tile_sched
  import tc_pkg::*;
#(
  parameter int N_UNIT    = N_UNIT_DEF,
  parameter int TILE_M    = TILE_M_DEF,
  parameter int TILE_K    = TILE_K_DEF,
  parameter int DW_DATA   = DW_DATA_DEF,
  parameter int DW_ACC    = DW_ACC_DEF,
  parameter int DW_CNT    = 8,
  parameter int ARRAY_LAT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [DW_CNT-1:0]         cmd_k_steps,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [N_UNIT*DW_DATA-1:0] a_data,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [N_UNIT*DW_DATA-1:0] b_data,
  output logic [N_UNIT*DW_DATA-1:0] arr_in_a,
  output logic [N_UNIT*DW_DATA-1:0] arr_in_b,
  input  logic [TILE_M*DW_DATA-1:0] arr_out,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [TILE_M*DW_ACC-1:0]  res_data,
  output logic                      busy
);

  localparam logic [TILE_M*TILE_K*DW_DATA-1:0] BUBBLE = '0;

  state_t               state;
  logic [DW_CNT-1:0]    k_steps;
  logic [DW_CNT-1:0]    issue_cnt;
  logic [DW_CNT-1:0]    acc_cnt;
  logic [DW_CNT-1:0]    acc_cnt_nx;
  logic [ARRAY_LAT-1:0] tags;
  logic                 issue;
  logic                 tag_exit;
  logic                 cmd_accept;
  logic                 last_issue;

  assign issue      = (state == RUN) && a_valid && b_valid;
  assign a_ready    = issue;
  assign b_ready    = issue;
  assign cmd_accept = cmd_valid && cmd_ready;
  assign tag_exit   = tags[ARRAY_LAT-1];
  assign acc_cnt_nx = acc_cnt + DW_CNT'(tag_exit);
  assign last_issue = issue && ((issue_cnt + DW_CNT'(1)) == k_steps);
  assign busy       = (state != IDLE);

  // Completion is judged on the post-edge accumulate count so OUT is entered on the very
  // edge that folds in the last beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      res_valid <= 1'b0;
      k_steps   <= '0;
      issue_cnt <= '0;
      acc_cnt   <= '0;
      tags      <= '0;
      arr_in_a  <= '0;
      arr_in_b  <= '0;
    end else begin
      tags      <= ARRAY_LAT'({tags, issue});
      arr_in_a  <= issue ? a_data : BUBBLE;
      arr_in_b  <= issue ? b_data : BUBBLE;
      issue_cnt <= cmd_accept ? '0 : (issue ? issue_cnt + DW_CNT'(1) : issue_cnt);
      acc_cnt   <= cmd_accept ? '0 : acc_cnt_nx;
      case (state)
        IDLE: begin
          if (cmd_accept) begin
            k_steps   <= cmd_k_steps;
            cmd_ready <= 1'b0;
            if (cmd_k_steps == '0) begin
              state     <= OUT;
              res_valid <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        RUN: begin
          if (last_issue) begin
            if (acc_cnt_nx == k_steps) begin
              state     <= OUT;
              res_valid <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (acc_cnt_nx == k_steps) begin
            state     <= OUT;
            res_valid <= 1'b1;
          end
        end
        OUT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar m = 0; m < TILE_M; m++) begin : g_lane
    tc_acc_lane #(
      .DW_DATA(DW_DATA),
      .DW_ACC (DW_ACC)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .clr    (cmd_accept),
      .add_en (tag_exit),
      .add_val(arr_out[m*DW_DATA +: DW_DATA]),
      .acc    (res_data[m*DW_ACC +: DW_ACC])
    );
  end

endmodule

// File: tb/tb_tc_tile_sched.sv
// Scoreboard bench for tc_tile_sched with a behavioural dot-product array stub.
// Expected tiles come from per-beat lane dot products summed and wrapped/saturated.
module tb_tc_tile_sched;

  localparam int N_UNIT    = 32;
  localparam int TILE_M    = 4;
  localparam int TILE_K    = 8;
  localparam int DW_DATA   = 8;
  localparam int DW_ACC    = 10;
  localparam int DW_CNT    = 8;
  localparam int ARRAY_LAT = 2;
  localparam int VW        = N_UNIT * DW_DATA;
  localparam int RW        = TILE_M * DW_ACC;
  localparam longint MAXV  = (64'd1 << DW_ACC) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [DW_CNT-1:0] cmd_k_steps = '0;
  logic              a_valid = 1'b0;
  logic              a_ready;
  logic [VW-1:0]     a_data = '0;
  logic              b_valid = 1'b0;
  logic              b_ready;
  logic [VW-1:0]     b_data = '0;
  logic [VW-1:0]     arr_in_a;
  logic [VW-1:0]     arr_in_b;
  logic [TILE_M*DW_DATA-1:0] arr_out;
  logic [TILE_M*DW_DATA-1:0] arr_pipe = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [RW-1:0]     res_data;
  logic              busy;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int cmd_cyc = 0;
  logic [VW-1:0] ba[$];
  logic [VW-1:0] bb[$];
  logic [RW-1:0] exp_q[$];

  logic          prev_rst = 1'b0;
  logic          prev_hs = 1'b0;
  logic [VW-1:0] prev_a = '0;
  logic [VW-1:0] prev_b = '0;

  tc_tile_sched #(
    .N_UNIT(N_UNIT), .TILE_M(TILE_M), .TILE_K(TILE_K), .DW_DATA(DW_DATA),
    .DW_ACC(DW_ACC), .DW_CNT(DW_CNT), .ARRAY_LAT(ARRAY_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k_steps(cmd_k_steps),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .arr_in_a(arr_in_a), .arr_in_b(arr_in_b), .arr_out(arr_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lane_dot(input logic [VW-1:0] a, input logic [VW-1:0] b, input int m);
    int s;
    s = 0;
    for (int k = 0; k < TILE_K; k++)
      s += int'(a[(m*TILE_K+k)*DW_DATA +: DW_DATA]) * int'(b[(m*TILE_K+k)*DW_DATA +: DW_DATA]);
    return s % 256;
  endfunction

  // Array stub: registered arr_in plus one stage gives the two-cycle array latency.
  always @(posedge clk) begin
    for (int m = 0; m < TILE_M; m++)
      arr_pipe[m*DW_DATA +: DW_DATA] <= DW_DATA'(lane_dot(arr_in_a, arr_in_b, m));
  end
  assign arr_out = arr_pipe;

  function automatic logic [RW-1:0] model_tile();
    logic [RW-1:0] r;
    longint tot;
    r = '0;
    for (int m = 0; m < TILE_M; m++) begin
      tot = 0;
      foreach (ba[i]) tot += longint'(lane_dot(ba[i], bb[i], m));
`ifdef TC_SCHED_SAT_EN
      if (tot > MAXV) tot = MAXV;
`else
      tot = tot % (MAXV + 1);
`endif
      r[m*DW_ACC +: DW_ACC] = DW_ACC'(tot);
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int w = 0; w < VW/32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic gen_beats(input int k, input int val_mode);
    logic [VW-1:0] va;
    logic [VW-1:0] vb;
    ba.delete();
    bb.delete();
    for (int i = 0; i < k; i++) begin
      va = rand_vec();
      vb = rand_vec();
      if (val_mode != 0) begin
        va = '0;
        vb = '0;
        for (int m = 0; m < TILE_M; m++) begin
          va[m*TILE_K*DW_DATA +: DW_DATA] = 8'd1;
          vb[m*TILE_K*DW_DATA +: DW_DATA] = (val_mode == 1) ? DW_DATA'(10*(m+1)) : 8'd255;
        end
      end
      ba.push_back(va);
      bb.push_back(vb);
    end
  endtask

  task automatic send_cmd(input int k, output bit ok);
    int n;
    bit rdy;
    n = 0;
    cmd_valid = 1'b1;
    cmd_k_steps = DW_CNT'(k);
    do begin
      @(negedge clk);
      rdy = cmd_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 50);
    cmd_valid = 1'b0;
    cmd_cyc = cyc;
    ok = rdy;
    if (!rdy) check_output("cmd_ready_timeout", 0, 1);
  endtask

  // stall: 0 = always valid, 1 = random valids, 2 = a always valid, b from pat bits
  task automatic feed(input int n, input int stall, input logic [31:0] pat);
    int i;
    int j;
    logic av;
    logic bv;
    i = 0;
    j = 0;
    while (i < n) begin
      if (stall == 2) begin
        av = 1'b1;
        bv = pat[j % 32];
      end else if (stall == 1) begin
        av = ($urandom_range(0, 3) != 0);
        bv = ($urandom_range(0, 3) != 0);
      end else begin
        av = 1'b1;
        bv = 1'b1;
      end
      a_valid = av;
      b_valid = bv;
      a_data = (av && bv) ? ba[i] : rand_vec();
      b_data = (av && bv) ? bb[i] : rand_vec();
      @(posedge clk); #1;
      if (av && bv) i++;
      j++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic collect(input int exp_lat, input int hold);
    int n;
    logic [RW-1:0] held;
    n = 0;
    while (!res_valid && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    if (!res_valid) begin
      check_output("res_valid_timeout", 0, 1);
      return;
    end
    if (exp_lat >= 0) check_output("latency", cyc - cmd_cyc, exp_lat);
    held = res_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_output("hold_res_data", res_data, held);
      check_output("hold_res_valid", res_valid, 1);
      check_output("hold_cmd_ready", cmd_ready, 0);
      check_output("hold_busy", busy, 1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check_output("post_res_valid", res_valid, 0);
    check_output("post_cmd_ready", cmd_ready, 1);
    check_output("post_busy", busy, 0);
  endtask

  // val_mode: 0 random, 1 lanes {40,30,20,10}, 2 lanes all 255, 3 reuse previous beats
  task automatic apply_stimulus(input int k, input int stall, input logic [31:0] pat,
                                input int hold, input int val_mode);
    bit ok;
    if (val_mode != 3) gen_beats(k, val_mode);
    send_cmd(k, ok);
    if (!ok) return;
    exp_q.push_back(model_tile());
    feed(k, stall, pat);
    collect((stall == 0) ? ((k == 0) ? 0 : k + ARRAY_LAT) : -1, hold);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_cmd_ready"}, cmd_ready, 0);
    check_output({tag, "_a_ready"}, a_ready, 0);
    check_output({tag, "_b_ready"}, b_ready, 0);
    check_output({tag, "_arr_in_a"}, arr_in_a, 0);
    check_output({tag, "_arr_in_b"}, arr_in_b, 0);
    check_output({tag, "_res_valid"}, res_valid, 0);
    check_output({tag, "_res_data"}, res_data, 0);
    check_output({tag, "_busy"}, busy, 0);
  endtask

  // Monitor: scoreboard pop on result handshake, joint-ready rule, bubble/issue contents.
  always @(negedge clk) begin
    if (reset && res_valid && res_ready) begin
      check_output("result_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check_output("res_data", res_data, exp_q.pop_front());
    end
    if (reset) begin
      check_output("a_ready", a_ready, a_valid && b_valid);
      check_output("b_ready", b_ready, a_valid && b_valid);
    end
    if (reset && prev_rst) begin
      check_output("arr_in_a", arr_in_a, prev_hs ? prev_a : '0);
      check_output("arr_in_b", arr_in_b, prev_hs ? prev_b : '0);
    end
    prev_rst = reset;
    prev_hs  = a_valid && b_valid;
    prev_a   = a_data;
    prev_b   = b_data;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    check_output("release_cmd_ready", cmd_ready, 1);

    apply_stimulus(3, 0, 32'd0, 0, 1);
    apply_stimulus(4, 2, 32'b1011001, 0, 0);
    apply_stimulus(4, 0, 32'd0, 0, 3);
    apply_stimulus(0, 0, 32'd0, 0, 0);
    apply_stimulus(5, 0, 32'd0, 0, 2);
    apply_stimulus(3, 1, 32'd0, 6, 0);
    apply_stimulus(2, 0, 32'd0, 0, 0);

    gen_beats(5, 0);
    send_cmd(5, ok);
    feed(2, 0, 32'd0);
    check_output("midjob_busy", busy, 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("midjob");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    apply_stimulus(1, 0, 32'd0, 0, 0);

    for (int j = 0; j < 12; j++)
      apply_stimulus($urandom_range(0, 12), $urandom_range(0, 1), 32'd0, $urandom_range(0, 3), 0);
    apply_stimulus(255, 1, 32'd0, 2, 0);

    repeat (3) @(posedge clk);
    #1;
    check_output("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
